stream_mux_rr: RTL and testbench

Parametrised N:1 stream multiplexer with a registered output stage, valid/ready handshaking on every port and a selectable arbitration mode: fixed select, as the older 2-bit 2:1 data-flow mux, or round-robin fair arbitration. It sits between several producer streams and one consumer. It replaces ad-hoc combinational muxes where back-pressure, fairness or a registered timing boundary is needed.

---
 rtl/mux_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/stream_mux_rr.sv | 100 ++++++++++
 tb/tb_stream_mux_rr.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer: arbitration mode encodings
// and the select-width helper.
package mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // A 2-channel mux still needs a 1-bit select, which $clog2 alone would not give for n=1.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after ptr,
// wrapping modulo CHANNELS.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int SELW     = clog2_min1(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req_i,
   input  logic [SELW-1:0]     ptr_i,
   output logic [SELW-1:0]     grant_o,
   output logic                grant_valid_o
);

   int best;

   // Distance 0 is the channel right after ptr; ptr itself is the last considered.
   function automatic int rr_dist(input int j, input int p);
      return (j - p - 1 + 2 * CHANNELS) % CHANNELS;
   endfunction

   always_comb begin
      grant_o       = '0;
      grant_valid_o = 1'b0;
      best          = CHANNELS;
      for (int j = 0; j < CHANNELS; j++) begin
         if (req_i[j] && (rr_dist(j, int'(ptr_i)) < best)) begin
            best          = rr_dist(j, int'(ptr_i));
            grant_o       = SELW'(j);
            grant_valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with a single registered output stage and
// selectable fixed-select or round-robin arbitration.
module stream_mux_rr
   import mux_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SELW     = clog2_min1(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] d_in,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SELW-1:0]           sel,
   input  logic                      rr_en,
   output logic [WIDTH-1:0]          out,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SELW-1:0]           out_chan
);

   logic [WIDTH-1:0] out_q, out_d;
   logic [SELW-1:0]  chan_q, chan_d;
   logic [SELW-1:0]  ptr_q, ptr_d;
   logic             valid_q, valid_d;

   logic [SELW-1:0]  arb_grant, gnt;
   logic             arb_valid, gnt_valid;
   logic             space, in_xfer;
   logic [WIDTH-1:0] gnt_data;

   rr_arbiter #(
      .CHANNELS (CHANNELS),
      .SELW     (SELW)
   ) u_arb (
      .req_i         (in_valid),
      .ptr_i         (ptr_q),
      .grant_o       (arb_grant),
      .grant_valid_o (arb_valid)
   );

   assign space = !valid_q || out_ready;

   always_comb begin
      if (rr_en == MODE_RR) begin
         gnt       = arb_grant;
         gnt_valid = arb_valid;
      end else begin
         gnt       = sel;
         gnt_valid = (int'(sel) < CHANNELS);
      end
   end

   // Ready is masked by rst so nothing is offered while reset is held.
   always_comb begin
      in_ready = '0;
      gnt_data = '0;
      for (int j = 0; j < CHANNELS; j++) begin
         in_ready[j] = gnt_valid && space && !rst && (gnt == SELW'(j));
         if (gnt == SELW'(j)) gnt_data = d_in[j*WIDTH +: WIDTH];
      end
   end

   assign in_xfer = |(in_ready & in_valid);

   always_comb begin
      out_d   = out_q;
      chan_d  = chan_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      if (in_xfer) begin
         out_d   = gnt_data;
         chan_d  = gnt;
         valid_d = 1'b1;
         if (rr_en == MODE_RR) ptr_d = gnt;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q   <= '0;
         chan_q  <= '0;
         valid_q <= 1'b0;
         ptr_q   <= SELW'(CHANNELS - 1);
      end else begin
         out_q   <= out_d;
         chan_q  <= chan_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out       = out_q;
   assign out_chan  = chan_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance for the main flows
// and a 3-channel instance for out-of-range select.
module tb_stream_mux_rr;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [4*W-1:0] d_in4;
   logic [3:0]     in_valid4, in_ready4;
   logic [1:0]     sel4, out_chan4;
   logic           rr_en4, out_valid4, out_ready4;
   logic [W-1:0]   out4;

   logic [3*W-1:0] d_in3;
   logic [2:0]     in_valid3, in_ready3;
   logic [1:0]     sel3, out_chan3;
   logic           rr_en3, out_valid3, out_ready3;
   logic [W-1:0]   out3;

   stream_mux_rr #(.WIDTH(W), .CHANNELS(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .d_in      (d_in4),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .sel       (sel4),
      .rr_en     (rr_en4),
      .out       (out4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .out_chan  (out_chan4)
   );

   stream_mux_rr #(.WIDTH(W), .CHANNELS(3)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .d_in      (d_in3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .sel       (sel3),
      .rr_en     (rr_en3),
      .out       (out3),
      .out_valid (out_valid3),
      .out_ready (out_ready3),
      .out_chan  (out_chan3)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      logic [1:0] exp_chan;

      rst        = 1'b1;
      d_in4      = {8'h44, 8'hA5, 8'h22, 8'h11};
      in_valid4  = 4'b0100;
      sel4       = 2'd2;
      rr_en4     = 1'b0;
      out_ready4 = 1'b1;
      d_in3      = {8'hC3, 8'hB2, 8'hA1};
      in_valid3  = 3'b111;
      sel3       = 2'd3;
      rr_en3     = 1'b0;
      out_ready3 = 1'b1;

      @(negedge clk);
      check("rst_in_ready",  32'(in_ready4),  32'h0);
      check("rst_out_valid", 32'(out_valid4), 32'h0);
      check("rst_out",       32'(out4),       32'h0);
      check("rst_out_chan",  32'(out_chan4),  32'h0);

      @(negedge clk);
      rst = 1'b0;
      #1;
      check("fix_in_ready",  32'(in_ready4),  32'h4);
      check("fix_pre_valid", 32'(out_valid4), 32'h0);
      check("oor_in_ready",  32'(in_ready3),  32'h0);

      @(negedge clk);
      check("fix_out",       32'(out4),       32'hA5);
      check("fix_chan",      32'(out_chan4),  32'h2);
      check("fix_valid",     32'(out_valid4), 32'h1);
      check("fix_in_ready2", 32'(in_ready4),  32'h4);
      check("oor_valid",     32'(out_valid3), 32'h0);

      out_ready4     = 1'b0;
      d_in4[23:16]   = 8'h5A;
      #1;
      check("bp_in_ready0", 32'(in_ready4), 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out",      32'(out4),       32'hA5);
         check("bp_chan",     32'(out_chan4),  32'h2);
         check("bp_valid",    32'(out_valid4), 32'h1);
         check("bp_in_ready", 32'(in_ready4),  32'h0);
      end

      out_ready4 = 1'b1;
      #1;
      check("bp_release_ready", 32'(in_ready4), 32'h4);
      @(negedge clk);
      check("drain_out",   32'(out4),       32'h5A);
      check("drain_valid", 32'(out_valid4), 32'h1);
      check("drain_chan",  32'(out_chan4),  32'h2);

      in_valid4 = 4'b0000;
      @(negedge clk);
      check("idle_valid",     32'(out_valid4), 32'h0);
      check("idle_out_hold",  32'(out4),       32'h5A);
      check("idle_chan_hold", 32'(out_chan4),  32'h2);
      check("oor_valid2",     32'(out_valid3), 32'h0);
      check("oor_in_ready2",  32'(in_ready3),  32'h0);

      // ptr was held at 3 through fixed mode, so channel 0 wins first
      rr_en4    = 1'b1;
      d_in4     = {8'h44, 8'h33, 8'h22, 8'h11};
      in_valid4 = 4'b1111;
      #1;
      check("rr_in_ready0", 32'(in_ready4), 32'h1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("rr_chan",  32'(out_chan4),  32'(i % 4));
         check("rr_out",   32'(out4),       32'(8'h11 * ((i % 4) + 1)));
         check("rr_valid", 32'(out_valid4), 32'h1);
      end
      @(negedge clk);
      check("rr_chan_9", 32'(out_chan4), 32'h0);
      @(negedge clk);
      check("rr_chan_10", 32'(out_chan4), 32'h1);

      #2;
      rst = 1'b1;
      #1;
      check("arst_valid",    32'(out_valid4), 32'h0);
      check("arst_out",      32'(out4),       32'h0);
      check("arst_chan",     32'(out_chan4),  32'h0);
      check("arst_in_ready", 32'(in_ready4),  32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arst_first_ready", 32'(in_ready4), 32'h1);
      @(negedge clk);
      check("arst_first_chan", 32'(out_chan4), 32'h0);
      check("arst_first_out",  32'(out4),      32'h11);

      rst = 1'b1;
      in_valid4 = 4'b1010;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("skip_in_ready0", 32'(in_ready4), 32'h2);
      for (int i = 0; i < 4; i++) begin
         exp_chan = (i % 2 == 0) ? 2'd1 : 2'd3;
         @(negedge clk);
         check("skip_chan", 32'(out_chan4), 32'(exp_chan));
         check("skip_out",  32'(out4),      (exp_chan == 2'd1) ? 32'h22 : 32'h44);
      end

      check("oor_valid3", 32'(out_valid3), 32'h0);
      sel3 = 2'd1;
      #1;
      check("fix3_in_ready", 32'(in_ready3), 32'h2);
      @(negedge clk);
      check("fix3_out",   32'(out3),       32'hB2);
      check("fix3_chan",  32'(out_chan3),  32'h1);
      check("fix3_valid", 32'(out_valid3), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
